memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory core.
// Each granted command runs IDLE -> ACCESS -> DONE. The core sees one registered
// access in ACCESS. The granted requester sees a one-cycle ready pulse in DONE.
// Read data is captured from the core on the DONE -> IDLE edge.
module memory_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,

    output logic              ce_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic [DATA_W-1:0] datai_mem,
    input  logic [DATA_W-1:0] datao_mem,

    output logic              grant_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Arbitration and command selection
    logic              any_valid;
    logic              start;
    logic              pick;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Transaction bookkeeping
    logic grant_q, grant_d;
    logic last_grant_q, last_grant_d;
    logic is_write_q, is_write_d;

    // Registered core interface
    logic              ce_q, ce_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Registered requester responses
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    // Pick the winner. On a tie the requester that did not win last time is chosen.
    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        start     = (state_q == StIdle) && any_valid;
        pick      = req0_valid ? (req1_valid & ~last_grant_q) : 1'b1;
        cmd_we    = pick ? req1_we    : req0_we;
        cmd_addr  = pick ? req1_addr  : req0_addr;
        cmd_wdata = pick ? req1_wdata : req0_wdata;
    end

    // FSM next state. Only IDLE waits on an input. ACCESS and DONE always last one cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (any_valid) state_d = StAccess;
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Grant and last-grant tracking. The command's direction is kept through DONE for read capture.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        if (start) begin
            grant_d    = pick;
            is_write_d = cmd_we;
        end
        if (state_q == StDone) begin
            last_grant_d = grant_q;
        end
    end

    // Core interface. The address and data registers double as the latched command,
    // so later changes on requester inputs cannot reach the core.
    always_comb begin
        ce_d    = start;
        we_d    = start & cmd_we;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (start) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end
    end

    // Responses. Ready is registered off ACCESS so that it is high for exactly the DONE cycle.
    // Read data is loaded on the DONE -> IDLE edge, and only for the requester that owns the read.
    always_comb begin
        ready0_d = (state_q == StAccess) && !grant_q;
        ready1_d = (state_q == StAccess) &&  grant_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if ((state_q == StDone) && !is_write_q) begin
            if (grant_q) begin
                rdata1_d = datao_mem;
            end else begin
                rdata0_d = datao_mem;
            end
        end
    end

    // State register and grant tracking. Async reset drops any in-flight command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            is_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
        end
    end

    // Registered core-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ce_q    <= ce_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Registered requester-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign ce_mem     = ce_q;
    assign we_mem     = we_q;
    assign addr_mem   = addr_q;
    assign datai_mem  = wdata_q;
    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != StIdle);

endmodule
